// File: rtl/nuc_coef_apply_if.sv
// rtl/nuc_coef_apply_if.sv - pixel, coefficient and corrected-pixel stream bundle for nuc_coef_apply
interface nuc_coef_apply_if #(
  parameter int PIX_W  = 14,
  parameter int COEF_W = 32
) ();
  logic [PIX_W-1:0]  s_pix_tdata;
  logic              s_pix_tvalid;
  logic              s_pix_tready;
  logic              s_pix_tuser;
  logic              s_pix_tlast;

  logic [COEF_W-1:0] s_coef_tdata;
  logic              s_coef_tvalid;
  logic              s_coef_tready;
  logic              s_coef_tuser;
  logic              s_coef_tlast;

  logic [PIX_W-1:0]  m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tuser;
  logic              m_axis_tlast;

  modport slave (
    input  s_pix_tdata, s_pix_tvalid, s_pix_tuser, s_pix_tlast,
    output s_pix_tready,
    input  s_coef_tdata, s_coef_tvalid, s_coef_tuser, s_coef_tlast,
    output s_coef_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s_pix_tdata, s_pix_tvalid, s_pix_tuser, s_pix_tlast,
    input  s_pix_tready,
    output s_coef_tdata, s_coef_tvalid, s_coef_tuser, s_coef_tlast,
    input  s_coef_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/nuc_coef_apply.sv
// rtl/nuc_coef_apply.sv - joins pixel and NUC coefficient streams, out = sat(round(pix*gain)+offset)
// Optional frame-alignment check and beat dropping: NUC_ALIGN_CHECK_EN
module nuc_coef_apply #(
  parameter int PIX_W  = 14,
  parameter int GAIN_W = 16,
  parameter int OFFS_W = 16,
  parameter int COEF_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  nuc_coef_apply_if.slave   bus,
  input  logic              nuc_en,
  input  logic              err_clr,
  output logic              err_sync
);

  localparam int PW = PIX_W + GAIN_W;
  localparam int SW = PW + 1;
  localparam int FB = GAIN_W - 2;
  localparam logic [PW:0]       RND_HALF = {{PW{1'b0}}, 1'b1} << (GAIN_W - 3);
  localparam logic [PIX_W-1:0]  PIX_MAX  = '1;

  logic              run;
  logic              ce;
  logic              both_valid;
  logic              join_beat;
  logic              drop_pix;
  logic              drop_coef;
  logic              en_act;
  logic              en_next;

  logic              v1, v2;
  logic [PIX_W-1:0]  p1_pix;
  logic [GAIN_W-1:0] p1_gain;
  logic [OFFS_W-1:0] p1_offs;
  logic              p1_user, p1_last, p1_en;

  logic [PW-1:0]     p2_prod;
  logic [PIX_W-1:0]  p2_pix;
  logic [OFFS_W-1:0] p2_offs;
  logic              p2_user, p2_last, p2_en;

  logic [PW:0]       rnd_sum;
  logic [PW:0]       rnd_q;
  logic signed [SW-1:0] s_sum;
  logic [PIX_W-1:0]  corr;

  // Holds both readies low through reset and the first cycle after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) run <= 1'b0;
    else          run <= 1'b1;
  end

  assign ce         = ~bus.m_axis_tvalid | bus.m_axis_tready;
  assign both_valid = run & bus.s_pix_tvalid & bus.s_coef_tvalid & ce;

`ifdef NUC_ALIGN_CHECK_EN
  logic tuser_mis;
  logic unused_sig;

  assign tuser_mis = bus.s_pix_tuser ^ bus.s_coef_tuser;
  assign join_beat = both_valid & ~tuser_mis;
  // The stream that is still mid-frame is drained until its next start of frame.
  assign drop_coef = both_valid & bus.s_pix_tuser & ~bus.s_coef_tuser;
  assign drop_pix  = both_valid & bus.s_coef_tuser & ~bus.s_pix_tuser;
  assign unused_sig = bus.s_coef_tlast;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    err_sync <= 1'b0;
    else if (err_clr)                err_sync <= 1'b0;
    else if (both_valid & tuser_mis) err_sync <= 1'b1;
  end
`else
  logic unused_sig;

  assign join_beat  = both_valid;
  assign drop_coef  = 1'b0;
  assign drop_pix   = 1'b0;
  assign err_sync   = 1'b0;
  assign unused_sig = &{1'b0, err_clr, bus.s_coef_tuser, bus.s_coef_tlast};
`endif

  assign bus.s_pix_tready  = join_beat | drop_pix;
  assign bus.s_coef_tready = join_beat | drop_coef;

  // Enable is sampled only at a frame's first joined pixel and held for the frame.
  assign en_next = (join_beat & bus.s_pix_tuser) ? nuc_en : en_act;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_act  <= 1'b0;
      v1      <= 1'b0;
      p1_pix  <= '0;
      p1_gain <= '0;
      p1_offs <= '0;
      p1_user <= 1'b0;
      p1_last <= 1'b0;
      p1_en   <= 1'b0;
    end else begin
      en_act <= en_next;
      if (ce) begin
        v1 <= join_beat;
        if (join_beat) begin
          p1_pix  <= bus.s_pix_tdata;
          p1_gain <= bus.s_coef_tdata[COEF_W-1 -: GAIN_W];
          p1_offs <= bus.s_coef_tdata[OFFS_W-1:0];
          p1_user <= bus.s_pix_tuser;
          p1_last <= bus.s_pix_tlast;
          p1_en   <= en_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2      <= 1'b0;
      p2_prod <= '0;
      p2_pix  <= '0;
      p2_offs <= '0;
      p2_user <= 1'b0;
      p2_last <= 1'b0;
      p2_en   <= 1'b0;
    end else if (ce) begin
      v2 <= v1;
      if (v1) begin
        p2_prod <= PW'(p1_pix) * PW'(p1_gain);
        p2_pix  <= p1_pix;
        p2_offs <= p1_offs;
        p2_user <= p1_user;
        p2_last <= p1_last;
        p2_en   <= p1_en;
      end
    end
  end

  // Round half up out of the Q2 gain fraction, add signed offset, clamp to pixel range.
  always_comb begin
    rnd_sum = {1'b0, p2_prod} + RND_HALF;
    rnd_q   = rnd_sum >> FB;
    s_sum   = $signed(rnd_q) + SW'($signed(p2_offs));
    if (s_sum[SW-1])              corr = '0;
    else if (|s_sum[SW-2:PIX_W])  corr = PIX_MAX;
    else                          corr = s_sum[PIX_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tuser  <= 1'b0;
      bus.m_axis_tlast  <= 1'b0;
    end else if (ce) begin
      bus.m_axis_tvalid <= v2;
      if (v2) begin
        bus.m_axis_tdata <= p2_en ? corr : p2_pix;
        bus.m_axis_tuser <= p2_user;
        bus.m_axis_tlast <= p2_last;
      end
    end
  end

endmodule

// File: tb/tb_nuc_coef_apply.sv
// tb/tb_nuc_coef_apply.sv - randomized self-checking bench for nuc_coef_apply against an arithmetic reference
module tb_nuc_coef_apply;

  localparam int PIX_W  = 14;
  localparam int GAIN_W = 16;
  localparam int OFFS_W = 16;
  localparam int COEF_W = 32;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic nuc_en  = 1'b0;
  logic err_clr = 1'b0;
  logic err_sync;

  always #5 clk = ~clk;

  nuc_coef_apply_if #(.PIX_W(PIX_W), .COEF_W(COEF_W)) bus ();

  nuc_coef_apply #(.PIX_W(PIX_W), .GAIN_W(GAIN_W), .OFFS_W(OFFS_W), .COEF_W(COEF_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .nuc_en   (nuc_en),
    .err_clr  (err_clr),
    .err_sync (err_sync)
  );

  typedef struct { logic [PIX_W-1:0] pix; logic user; logic last; logic en; } pix_beat_t;
  typedef struct { logic [COEF_W-1:0] data; logic user; logic last; } coef_beat_t;
  typedef struct { logic [PIX_W-1:0] data; logic user; logic last; } out_beat_t;

  pix_beat_t  pix_q[$];
  coef_beat_t coef_q[$];
  out_beat_t  exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [PIX_W-1:0] ref_pix(logic [PIX_W-1:0] pix, logic [COEF_W-1:0] coef, logic en);
    longint gain, offs, r, s;
    if (!en) return pix;
    gain = longint'(coef[COEF_W-1 -: GAIN_W]);
    offs = longint'($signed(coef[OFFS_W-1:0]));
    r = (longint'(pix) * gain + 2 ** (GAIN_W - 3)) / (2 ** (GAIN_W - 2));
    s = r + offs;
    if (s < 0) return '0;
    if (s > 2 ** PIX_W - 1) return '1;
    return PIX_W'(s);
  endfunction

  function automatic void build_exp(input int coef_off);
    logic en_cur = 1'b0;
    out_beat_t o;
    exp_q.delete();
    for (int i = 0; i < pix_q.size(); i++) begin
      if (pix_q[i].user) en_cur = pix_q[i].en;
      o.data = ref_pix(pix_q[i].pix, coef_q[i + coef_off].data, en_cur);
      o.user = pix_q[i].user;
      o.last = pix_q[i].last;
      exp_q.push_back(o);
    end
  endfunction

  function automatic void push_pair(logic [PIX_W-1:0] p, logic [COEF_W-1:0] c, logic u, logic l, logic en);
    pix_beat_t  pb;
    coef_beat_t cb;
    pb.pix = p; pb.user = u; pb.last = l; pb.en = en;
    cb.data = c; cb.user = u; cb.last = l;
    pix_q.push_back(pb);
    coef_q.push_back(cb);
  endfunction

  // en_mode: 0 = off, 1 = on, 2 = random per beat (only the first beat of a frame matters)
  function automatic void add_frame(input int lines, input int llen, input int en_mode);
    logic [PIX_W-1:0]  p;
    logic [GAIN_W-1:0] g;
    logic [OFFS_W-1:0] o;
    logic en;
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < llen; x++) begin
        case ($urandom_range(3))
          0: p = '0;
          1: p = '1;
          default: p = PIX_W'($urandom);
        endcase
        case ($urandom_range(3))
          0: g = GAIN_W'($urandom);
          1: g = 16'h4000;
          2: g = 16'hFFFF;
          default: g = 16'h8000;
        endcase
        o  = OFFS_W'($urandom);
        en = (en_mode == 2) ? 1'($urandom) : 1'(en_mode);
        push_pair(p, {g, o}, (x == 0 && y == 0), (x == llen - 1), en);
      end
    end
  endfunction

  task automatic idle_inputs();
    bus.s_pix_tvalid  = 1'b0;
    bus.s_coef_tvalid = 1'b0;
    bus.s_pix_tuser   = 1'b0;
    bus.s_coef_tuser  = 1'b0;
    bus.s_pix_tlast   = 1'b0;
    bus.s_coef_tlast  = 1'b0;
    bus.s_pix_tdata   = '0;
    bus.s_coef_tdata  = '0;
  endtask

  task automatic run_stream(input string name, input int pb, input int cb, input int rb,
                            input int stall_at, input int stall_len, input bit chk_lat);
    int pi = 0, ci = 0, oi = 0, cyc = 0, pix0_cyc = -1, extra = 0;
    int n = pix_q.size();
    int limit = 400 + 20 * n;
    bit held = 1'b0;
    logic [PIX_W-1:0] h_data;
    logic h_user, h_last;
    while (oi < n && cyc < limit) begin
      @(negedge clk);
      if (pi < n && $urandom_range(99) >= pb) begin
        bus.s_pix_tvalid = 1'b1;
        bus.s_pix_tdata  = pix_q[pi].pix;
        bus.s_pix_tuser  = pix_q[pi].user;
        bus.s_pix_tlast  = pix_q[pi].last;
      end else begin
        bus.s_pix_tvalid = 1'b0;
        bus.s_pix_tdata  = PIX_W'($urandom);
        bus.s_pix_tuser  = 1'($urandom);
        bus.s_pix_tlast  = 1'($urandom);
      end
      nuc_en = pix_q[(pi < n) ? pi : n - 1].en;
      if (ci < coef_q.size() && $urandom_range(99) >= cb) begin
        bus.s_coef_tvalid = 1'b1;
        bus.s_coef_tdata  = coef_q[ci].data;
        bus.s_coef_tuser  = coef_q[ci].user;
        bus.s_coef_tlast  = coef_q[ci].last;
      end else begin
        bus.s_coef_tvalid = 1'b0;
        bus.s_coef_tdata  = $urandom;
        bus.s_coef_tuser  = 1'($urandom);
        bus.s_coef_tlast  = 1'($urandom);
      end
      if (cyc >= stall_at && cyc < stall_at + stall_len) bus.m_axis_tready = 1'b0;
      else bus.m_axis_tready = ($urandom_range(99) >= rb);
      #1;
      if (held) begin
        n_cmp++;
        if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== h_data ||
            bus.m_axis_tuser !== h_user || bus.m_axis_tlast !== h_last) begin
          n_bad++;
          $display("FAIL %s stall_hold cyc=%0d: got v=%b d=%0d u=%b l=%b, want v=1 d=%0d u=%b l=%b",
                   name, cyc, bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast,
                   h_data, h_user, h_last);
        end
      end
`ifndef NUC_ALIGN_CHECK_EN
      n_cmp++;
      if (bus.s_pix_tready !== bus.s_coef_tready ||
          (bus.s_pix_tready === 1'b1 && !(bus.s_pix_tvalid && bus.s_coef_tvalid))) begin
        n_bad++;
        $display("FAIL %s ready_rule cyc=%0d: got prdy=%b crdy=%b pv=%b cv=%b, want readies equal and only with both valid",
                 name, cyc, bus.s_pix_tready, bus.s_coef_tready, bus.s_pix_tvalid, bus.s_coef_tvalid);
      end
`endif
      if (bus.s_pix_tvalid && bus.s_pix_tready) begin
        if (pi == 0) pix0_cyc = cyc;
        pi++;
      end
      if (bus.s_coef_tvalid && bus.s_coef_tready) ci++;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        n_cmp++;
        if (bus.m_axis_tdata !== exp_q[oi].data || bus.m_axis_tuser !== exp_q[oi].user ||
            bus.m_axis_tlast !== exp_q[oi].last) begin
          n_bad++;
          $display("FAIL %s out[%0d]: got d=%0d u=%b l=%b, want d=%0d u=%b l=%b", name, oi,
                   bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast,
                   exp_q[oi].data, exp_q[oi].user, exp_q[oi].last);
        end
        if (chk_lat && oi == 0) begin
          n_cmp++;
          if (cyc - pix0_cyc !== 3) begin
            n_bad++;
            $display("FAIL %s latency: got %0d cycles, want 3", name, cyc - pix0_cyc);
          end
        end
        oi++;
      end
      held   = bus.m_axis_tvalid && !bus.m_axis_tready;
      h_data = bus.m_axis_tdata;
      h_user = bus.m_axis_tuser;
      h_last = bus.m_axis_tlast;
      cyc++;
    end
    n_cmp++;
    if (oi != n) begin
      n_bad++;
      $display("FAIL %s timeout: got %0d outputs, want %0d", name, oi, n);
    end
    @(negedge clk);
    idle_inputs();
    bus.m_axis_tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (bus.m_axis_tvalid) extra++;
      @(negedge clk);
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL %s extra_outputs: got %0d, want 0", name, extra);
    end
  endtask

  task automatic test_reset();
    bus.s_pix_tvalid  = 1'b1;
    bus.s_coef_tvalid = 1'b1;
    bus.m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tdata !== '0 || bus.m_axis_tuser !== 1'b0 ||
        bus.m_axis_tlast !== 1'b0 || err_sync !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b d=%0d u=%b l=%b err=%b, want all 0",
               bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast, err_sync);
    end
    n_cmp++;
    if (bus.s_pix_tready !== 1'b0 || bus.s_coef_tready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_readies: got %b/%b, want 0/0", bus.s_pix_tready, bus.s_coef_tready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.s_pix_tready !== 1'b0 || bus.s_coef_tready !== 1'b0) begin
      n_bad++;
      $display("FAIL release_readies: got %b/%b, want 0/0", bus.s_pix_tready, bus.s_coef_tready);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.s_pix_tready !== 1'b1 || bus.s_coef_tready !== 1'b1) begin
      n_bad++;
      $display("FAIL run_readies: got %b/%b, want 1/1", bus.s_pix_tready, bus.s_coef_tready);
    end
    idle_inputs();
  endtask

  task automatic test_directed();
    out_beat_t o;
    pix_q.delete(); coef_q.delete(); exp_q.delete();
    push_pair(14'd1000, {16'h4000, 16'h0000}, 1'b1, 1'b0, 1'b1);
    push_pair(14'd3,    {16'h2000, 16'h0000}, 1'b0, 1'b0, 1'b1);
    push_pair(14'd50,   {16'h4000, 16'hFF9C}, 1'b0, 1'b0, 1'b1);
    push_pair(14'd9000, {16'h8000, 16'hFF9C}, 1'b0, 1'b1, 1'b1);
    o.data = 14'd1000;  o.user = 1'b1; o.last = 1'b0; exp_q.push_back(o);
    o.data = 14'd2;     o.user = 1'b0; o.last = 1'b0; exp_q.push_back(o);
    o.data = 14'd0;     o.user = 1'b0; o.last = 1'b0; exp_q.push_back(o);
    o.data = 14'd16383; o.user = 1'b0; o.last = 1'b1; exp_q.push_back(o);
    run_stream("directed", 0, 0, 0, 0, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    pix_q.delete(); coef_q.delete();
    add_frame(1, 64, 1);
    build_exp(0);
    run_stream("backpressure", 0, 0, 0, 30, 5, 1'b0);
  endtask

  task automatic test_random();
    pix_q.delete(); coef_q.delete();
    for (int f = 0; f < 4; f++) add_frame(2, 20, 2);
    build_exp(0);
    run_stream("random", 20, 20, 25, 0, 0, 1'b0);
  endtask

  task automatic test_enable_latch();
    pix_q.delete(); coef_q.delete();
    for (int i = 0; i < 10; i++)
      push_pair(PIX_W'(100 + 37 * i), {16'h6000, 16'd7}, (i == 0), (i == 9), (i < 4));
    for (int i = 0; i < 6; i++)
      push_pair((i == 0) ? 14'd1234 : PIX_W'($urandom), {16'h6000, 16'd7}, (i == 0), (i == 5), 1'b0);
    build_exp(0);
    run_stream("enable_latch", 10, 10, 10, 0, 0, 1'b0);
  endtask

  task automatic test_misalign();
    coef_beat_t cb;
    pix_q.delete(); coef_q.delete();
    for (int i = 0; i < 3; i++) begin
      cb.data = $urandom; cb.user = 1'b0; cb.last = 1'b0;
      coef_q.push_back(cb);
    end
    add_frame(1, 12, 1);
`ifdef NUC_ALIGN_CHECK_EN
    build_exp(3);
`else
    build_exp(0);
`endif
    run_stream("misalign", 15, 15, 15, 0, 0, 1'b0);
    n_cmp++;
`ifdef NUC_ALIGN_CHECK_EN
    if (err_sync !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sync_set: got %b, want 1", err_sync);
    end
`else
    if (err_sync !== 1'b0) begin
      n_bad++;
      $display("FAIL err_sync_tied: got %b, want 0", err_sync);
    end
`endif
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    n_cmp++;
    if (err_sync !== 1'b0) begin
      n_bad++;
      $display("FAIL err_sync_clr: got %b, want 0", err_sync);
    end
  endtask

  task automatic test_reset_flush();
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.s_pix_tvalid  = 1'b1;
      bus.s_coef_tvalid = 1'b1;
      bus.s_pix_tdata   = PIX_W'($urandom);
      bus.s_coef_tdata  = $urandom;
      bus.s_pix_tuser   = (i == 0);
      bus.s_coef_tuser  = (i == 0);
      nuc_en            = 1'b1;
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tdata !== '0) begin
      n_bad++;
      $display("FAIL flush_reset: got v=%b d=%0d, want v=0 d=0", bus.m_axis_tvalid, bus.m_axis_tdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus.m_axis_tready = 1'b1;
    #1;
    n_cmp++;
    if (bus.s_pix_tready !== 1'b0 || bus.m_axis_tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_release: got prdy=%b v=%b, want 0/0", bus.s_pix_tready, bus.m_axis_tvalid);
    end
    idle_inputs();
    pix_q.delete(); coef_q.delete();
    add_frame(1, 16, 2);
    build_exp(0);
    run_stream("after_flush", 10, 10, 10, 0, 0, 1'b1);
  endtask

  initial begin
    idle_inputs();
    bus.m_axis_tready = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_enable_latch();
    test_misalign();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
